alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Reservation-station-style scheduler that shares the single integer ALU among in-flight ALU micro-ops in the out-of-order core.
- Accepts decoded ops (already carrying ALU_operation_t from ALU-op decode) from dispatch.
- Tracks operand readiness via common-data-bus (CDB) wakeup and issues the oldest fully-ready op to the ALU through a registered valid/ready stage.

Parameters:
- DEPTH, 8, number of queue entries (power of two, ≥2)
- XLEN, 32, operand width
- TAG_W, 6, physical/ROB tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; discards all entries and the issue register
- disp_valid  in  1  dispatch offers an op
- disp_ready  out  1  a free entry exists
- disp_op  in  ALU_operation_t  ALU operation
- disp_src1_rdy  in  1  src1 value valid
- disp_src1_tag  in  TAG_W  src1 producer tag
- disp_src1_val  in  XLEN  src1 value
- disp_src2_rdy  in  1  src2 value valid
- disp_src2_tag  in  TAG_W  src2 producer tag
- disp_src2_val  in  XLEN  src2 value
- disp_dst_tag  in  TAG_W  result tag
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_val  in  XLEN  broadcast value
- iss_valid  out  1  issue register holds an op
- iss_ready  in  1  ALU accepts the op
- iss_op  out  ALU_operation_t  issued operation
- iss_src1  out  XLEN  operand 1
- iss_src2  out  XLEN  operand 2
- iss_dst_tag  out  TAG_W  result tag
- occupancy  out  $clog2(DEPTH+1)  valid entries in the queue, excluding the issue register

Behaviour:
- Reset, async on rst_n low:
  - All entry valid bits 0.
  - iss_valid=0; iss_op=noALU; iss_src1/iss_src2/iss_dst_tag=0.
  - occupancy=0; age state cleared.
- Dispatch:
  - Handshake completes when disp_valid && disp_ready.
  - The op is written to the lowest-index free entry at the clock edge.
  - disp_ready = (occupancy != DEPTH). It uses only registered state; an entry freed in the same cycle does not raise it.
- Dispatch bypass: if cdb_valid and cdb_tag equals a non-ready source tag in the same cycle, the entry is written with that source ready and value = cdb_val.
- Wakeup:
  - Every valid entry with a non-ready source whose tag equals cdb_tag (cdb_valid=1) captures cdb_val and sets that source ready at the edge.
  - Both sources may wake on one broadcast.
- Selection:
  - An entry is eligible when valid && src1_rdy && src2_rdy, using registered state, so minimum dispatch-to-iss_valid latency is 1 cycle for ready ops.
  - A wakeup-to-issue register takes 1 cycle.
  - Oldest eligible entry wins. Age is tracked by a DEPTH×DEPTH age matrix: on allocation, the new entry's row is set older-than none and all other valid entries are marked older than it.
- Issue register:
  - Loads when (!iss_valid || iss_ready) and an eligible entry exists. The selected entry is freed at the same edge.
  - If iss_valid && !iss_ready, outputs hold stable and no entry is freed.
  - If iss_ready with no eligible entry, iss_valid drops to 0.
- Occupancy: next = occupancy + alloc − free. Allocate and free in the same cycle leaves it unchanged.
- Flush:
  - Next edge clears all entry valid bits and iss_valid; iss_op=noALU.
  - A dispatch presented in the flush cycle is dropped.
  - Flush has priority over dispatch, wakeup and issue.
- Reset mid-operation: immediate clear regardless of handshake state; no partial outputs retained.
- Tags are compared on full TAG_W width only; no tag-zero special case.

Decomposition:
- ALU_operation_t and noALU stay in the shared opTypes package.
- Add to that package an iq_entry_t struct (valid, op, src1/src2 rdy/tag/val, dst_tag) parameterised by XLEN/TAG_W constants.
- Natural sub-module: iq_age_select — age matrix plus eligible-vector → one-hot oldest grant. It is combinational selection with registered matrix update.

Test Plan:
- Dispatch addALU, both sources ready, iss_ready=1 → iss_valid=1 one cycle later, iss_op=addALU, operands match; occupancy returns to 0.
- Dispatch A (src2 waits tag 5), then B ready; cdb tag 5 val 0x1234 → B issues first. A issues the cycle after wakeup with iss_src2=0x1234.
- Fill 8 entries with non-ready sources → disp_ready=0 and occupancy=8. One CDB wakeup plus iss_ready → disp_ready=1 the following cycle.
- Hold iss_ready=0 with valid issue → iss_* stable for 5 cycles, occupancy unchanged. Raise iss_ready → next-oldest loads.
- Dispatch with src1 tag 9 in the same cycle cdb_tag=9 val 0xDEAD → entry ready; issues next cycle with iss_src1=0xDEAD.
- Four entries plus valid issue register, assert flush with disp_valid=1 → next cycle occupancy=0, iss_valid=0, and the dispatched op is never issued.

Source files
------------

// File: rtl/opTypes.sv
// opTypes: shared ALU operation encoding and issue-queue entry layout
package opTypes;
    localparam int IQ_XLEN = 32;
    localparam int IQ_TAG_W = 6;
    typedef enum logic [3:0] {
        noALU, addALU, subALU, andALU, orALU, xorALU,
        sllALU, srlALU, sraALU, sltALU, sltuALU, luiALU
    } ALU_operation_t;
    typedef struct packed {
        logic                valid;
        ALU_operation_t      op;
        logic                src1_rdy;
        logic [IQ_TAG_W-1:0] src1_tag;
        logic [IQ_XLEN-1:0]  src1_val;
        logic                src2_rdy;
        logic [IQ_TAG_W-1:0] src2_tag;
        logic [IQ_XLEN-1:0]  src2_val;
        logic [IQ_TAG_W-1:0] dst_tag;
    } iq_entry_t;
endpackage

// File: rtl/iq_age_select.sv
// iq_age_select: age matrix with one-hot grant of the oldest eligible entry
module iq_age_select #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] vld,
    input  logic [DEPTH-1:0] elig,
    output logic [DEPTH-1:0] grant
);
    // older[j][i] set means entry j was allocated before entry i
    logic [DEPTH-1:0] older [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        else if (flush)
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        else
            for (int k = 0; k < DEPTH; k++)
                if (alloc[k]) begin
                    older[k] <= '0;
                    for (int j = 0; j < DEPTH; j++)
                        if (j != k) older[j][k] <= vld[j];
                end
    always_comb begin
        grant = elig;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (elig[j] && older[j][i]) grant[i] = 1'b0;
    end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: CDB-woken reservation station issuing the oldest ready op
// to the single ALU through a registered valid/ready stage
module alu_issue_queue import opTypes::*; #(
    parameter int DEPTH = 8,
    parameter int XLEN  = IQ_XLEN,
    parameter int TAG_W = IQ_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  ALU_operation_t             disp_op,
    input  logic                       disp_src1_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [XLEN-1:0]            disp_src1_val,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [XLEN-1:0]            disp_src2_val,
    input  logic [TAG_W-1:0]           disp_dst_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_val,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output ALU_operation_t             iss_op,
    output logic [XLEN-1:0]            iss_src1,
    output logic [XLEN-1:0]            iss_src2,
    output logic [TAG_W-1:0]           iss_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH+1);
    iq_entry_t q [DEPTH];
    iq_entry_t new_e;
    logic [DEPTH-1:0] vld, elig, grant, free_oh, alloc_vec, free_vec;
    logic alloc, load, found;
    ALU_operation_t sel_op;
    logic [XLEN-1:0] sel_s1, sel_s2;
    logic [TAG_W-1:0] sel_dst;
    assign disp_ready = occupancy != OCC_W'(DEPTH);
    assign alloc = disp_valid && disp_ready && !flush;
    assign load = (!iss_valid || iss_ready) && |elig;
    assign alloc_vec = alloc ? free_oh : '0;
    assign free_vec = load ? grant : '0;
    always_comb begin
        free_oh = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = q[i].valid;
            elig[i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy;
            if (!q[i].valid && !found) begin
                free_oh[i] = 1'b1;
                found = 1'b1;
            end
        end
    end
    // a broadcast in the dispatch cycle is captured directly into the new entry
    always_comb begin
        new_e.valid = 1'b1;
        new_e.op = disp_op;
        new_e.src1_rdy = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
        new_e.src1_tag = disp_src1_tag;
        new_e.src1_val = disp_src1_rdy ? disp_src1_val : cdb_val;
        new_e.src2_rdy = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
        new_e.src2_tag = disp_src2_tag;
        new_e.src2_val = disp_src2_rdy ? disp_src2_val : cdb_val;
        new_e.dst_tag = disp_dst_tag;
    end
    always_comb begin
        sel_op = noALU;
        sel_s1 = '0;
        sel_s2 = '0;
        sel_dst = '0;
        for (int i = 0; i < DEPTH; i++)
            if (grant[i]) begin
                sel_op = q[i].op;
                sel_s1 = q[i].src1_val;
                sel_s2 = q[i].src2_val;
                sel_dst = q[i].dst_tag;
            end
    end
    iq_age_select #(.DEPTH(DEPTH)) u_age (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc(alloc_vec), .vld(vld), .elig(elig), .grant(grant)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        else if (flush)
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        else
            for (int i = 0; i < DEPTH; i++)
                if (alloc_vec[i]) q[i] <= new_e;
                else begin
                    if (free_vec[i]) q[i].valid <= 1'b0;
                    if (cdb_valid && !q[i].src1_rdy && q[i].src1_tag == cdb_tag) begin
                        q[i].src1_rdy <= 1'b1;
                        q[i].src1_val <= cdb_val;
                    end
                    if (cdb_valid && !q[i].src2_rdy && q[i].src2_tag == cdb_tag) begin
                        q[i].src2_rdy <= 1'b1;
                        q[i].src2_val <= cdb_val;
                    end
                end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_op <= noALU;
            iss_src1 <= '0;
            iss_src2 <= '0;
            iss_dst_tag <= '0;
            occupancy <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
            iss_op <= noALU;
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(alloc) - OCC_W'(load);
            if (!iss_valid || iss_ready) iss_valid <= |elig;
            if (load) begin
                iss_op <= sel_op;
                iss_src1 <= sel_s1;
                iss_src2 <= sel_s2;
                iss_dst_tag <= sel_dst;
            end
        end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed vectors for alu_issue_queue
module tb_alu_issue_queue;
    import opTypes::*;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic disp_valid = 1'b0, disp_ready;
    ALU_operation_t disp_op = noALU;
    logic disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic [5:0] disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
    logic [31:0] disp_src1_val = '0, disp_src2_val = '0;
    logic cdb_valid = 1'b0;
    logic [5:0] cdb_tag = '0;
    logic [31:0] cdb_val = '0;
    logic iss_valid, iss_ready = 1'b0;
    ALU_operation_t iss_op;
    logic [31:0] iss_src1, iss_src2;
    logic [5:0] iss_dst_tag;
    logic [3:0] occupancy;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    alu_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
        .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
        .disp_dst_tag(disp_dst_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst_tag(iss_dst_tag),
        .occupancy(occupancy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic disp(input ALU_operation_t op, input logic r1, input logic [5:0] t1,
                        input logic [31:0] v1, input logic r2, input logic [5:0] t2,
                        input logic [31:0] v2, input logic [5:0] dst);
        disp_valid = 1'b1;
        disp_op = op;
        disp_src1_rdy = r1;
        disp_src1_tag = t1;
        disp_src1_val = v1;
        disp_src2_rdy = r2;
        disp_src2_tag = t2;
        disp_src2_val = v2;
        disp_dst_tag = dst;
    endtask
    task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] val);
        cdb_valid = v;
        cdb_tag = t;
        cdb_val = val;
    endtask
    initial begin
        tick();
        tick();
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_op", iss_op, noALU);
        check("rst_occ", occupancy, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_dst", iss_dst_tag, 0);
        rst_n = 1'b1;
        iss_ready = 1'b1;
        // single ready op
        disp(addALU, 1, 0, 5, 1, 0, 7, 3);
        tick();
        disp_valid = 1'b0;
        check("t1_occ1", occupancy, 1);
        check("t1_nv", iss_valid, 0);
        tick();
        check("t1_valid", iss_valid, 1);
        check("t1_op", iss_op, addALU);
        check("t1_s1", iss_src1, 5);
        check("t1_s2", iss_src2, 7);
        check("t1_dst", iss_dst_tag, 3);
        check("t1_occ0", occupancy, 0);
        tick();
        check("t1_drop", iss_valid, 0);
        // wakeup ordering
        disp(subALU, 1, 0, 1, 0, 5, 0, 10);
        tick();
        disp(andALU, 1, 0, 2, 1, 0, 3, 11);
        tick();
        disp_valid = 1'b0;
        check("t2_occ2", occupancy, 2);
        cdb(1, 5, 32'h1234);
        tick();
        cdb(0, 0, 0);
        check("t2_b_dst", iss_dst_tag, 11);
        check("t2_b_op", iss_op, andALU);
        check("t2_occ1", occupancy, 1);
        tick();
        check("t2_a_valid", iss_valid, 1);
        check("t2_a_dst", iss_dst_tag, 10);
        check("t2_a_s2", iss_src2, 32'h1234);
        check("t2_a_s1", iss_src1, 1);
        tick();
        check("t2_idle", iss_valid, 0);
        // fill to capacity
        for (int i = 0; i < 8; i++) begin
            disp(orALU, 0, 6'(20 + i), 0, 1, 0, 32'(i), 6'(i));
            tick();
        end
        disp_valid = 1'b0;
        check("t3_occ8", occupancy, 8);
        check("t3_full", disp_ready, 0);
        check("t3_nv", iss_valid, 0);
        cdb(1, 20, 32'h55);
        tick();
        cdb(0, 0, 0);
        check("t3_still_full", disp_ready, 0);
        tick();
        check("t3_ready", disp_ready, 1);
        check("t3_occ7", occupancy, 7);
        check("t3_dst", iss_dst_tag, 0);
        check("t3_s1", iss_src1, 32'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_occ", occupancy, 0);
        check("t3_flush_v", iss_valid, 0);
        // back-pressure and age order (Z lands in a lower index than Y)
        iss_ready = 1'b0;
        disp(orALU, 1, 0, 32'h10, 1, 0, 32'h11, 1);
        tick();
        disp(xorALU, 1, 0, 32'h20, 1, 0, 32'h21, 2);
        tick();
        disp(sllALU, 1, 0, 32'h30, 1, 0, 32'h31, 3);
        tick();
        disp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_v", iss_valid, 1);
            check("t4_hold_dst", iss_dst_tag, 1);
            check("t4_hold_s1", iss_src1, 32'h10);
            check("t4_hold_occ", occupancy, 2);
            tick();
        end
        iss_ready = 1'b1;
        tick();
        check("t4_y_dst", iss_dst_tag, 2);
        check("t4_y_op", iss_op, xorALU);
        check("t4_occ1", occupancy, 1);
        tick();
        check("t4_z_dst", iss_dst_tag, 3);
        check("t4_z_s2", iss_src2, 32'h31);
        check("t4_occ0", occupancy, 0);
        tick();
        check("t4_idle", iss_valid, 0);
        // dispatch-cycle bypass
        disp(addALU, 0, 9, 0, 1, 0, 2, 4);
        cdb(1, 9, 32'hDEAD);
        tick();
        disp_valid = 1'b0;
        cdb(0, 0, 0);
        check("t5_occ1", occupancy, 1);
        tick();
        check("t5_valid", iss_valid, 1);
        check("t5_s1", iss_src1, 32'hDEAD);
        check("t5_dst", iss_dst_tag, 4);
        tick();
        // flush with a dispatch in the same cycle
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(subALU, 1, 0, 32'(i), 1, 0, 1, 6'(30 + i));
            tick();
        end
        check("t6_occ4", occupancy, 4);
        check("t6_v", iss_valid, 1);
        check("t6_dst", iss_dst_tag, 30);
        disp(luiALU, 1, 0, 9, 1, 0, 9, 40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        iss_ready = 1'b1;
        check("t6_occ0", occupancy, 0);
        check("t6_nv", iss_valid, 0);
        check("t6_op", iss_op, noALU);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_never", iss_valid, 0);
            check("t6_occ", occupancy, 0);
        end
        // asynchronous reset mid-operation
        iss_ready = 1'b0;
        disp(addALU, 1, 0, 1, 1, 0, 1, 7);
        tick();
        tick();
        disp_valid = 1'b0;
        check("t7_pre_v", iss_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_v", iss_valid, 0);
        check("t7_rst_occ", occupancy, 0);
        check("t7_rst_dst", iss_dst_tag, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
